// File: rtl/lfsr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_arb_pkg
//  Purpose  : Shared FSM state encoding and LFSR tap positions for lfsr_arb.
//  Revision : 1.0  initial release
// ============================================================================
package lfsr_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SEED  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Feedback taps of the LFSR; words narrower than TAP_HI+2 bits cannot host them
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 1;
  localparam int DW_MIN = 6;

endpackage : lfsr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin winner select. The search begins at
//             i_ptr and wraps; the first set request bit wins (one-hot out).
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Walk the requesters starting at the pointer; keep only the first hit
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/lfsr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_arb
//  Purpose  : Round-robin arbiter that hands out bursts of pseudo-random words
//             from an internal LFSR, with an optional seed-load path.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_arb
  import lfsr_arb_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter int          DW        = 6,
  parameter int          BURST_LEN = 4,
  parameter int unsigned SEED_DEF  = 1
) (
  input  logic             i_clk_arb,
  input  logic             i_rst_arb,
  input  logic [N_REQ-1:0] i_req_arb,
  input  logic             i_seed_vld_arb,
  input  logic [DW-1:0]    i_seed_arb,
  input  logic             i_rdy_arb,
  output logic [N_REQ-1:0] o_gnt_arb,
  output logic             o_vld_arb,
  output logic [DW-1:0]    o_rnd_arb,
  output logic             o_busy_arb
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [DW-1:0] c_SEED_RST = (DW'(SEED_DEF) == '0) ? DW'(1) : DW'(SEED_DEF);
  localparam logic [CW-1:0] c_CNT_LD   = CW'(BURST_LEN - 1);

  // The tap at bit TAP_HI needs at least DW_MIN bits
  if (DW < DW_MIN) begin : g_dw_chk
    $error("lfsr_arb: DW must be at least 6");
  end

  state_t             r_state, w_state_nxt;
  logic [DW-1:0]      r_lfsr;
  logic [DW-1:0]      r_seed;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_win;
  logic [CW-1:0]      r_cnt;
  logic [N_REQ-1:0]   r_gnt;

  logic [N_REQ-1:0]   w_pick;
  logic [PW-1:0]      w_pick_idx;
  logic [DW-1:0]      w_lfsr_nxt;
  logic [PW-1:0]      w_ptr_nxt;
  logic               w_hs;
  logic               w_req_ok;
  logic               w_seed_cap;
  logic               w_seed_load;
  logic               w_start;
  logic               w_adv;
  logic               w_end;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .i_req (i_req_arb),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // Encode the one-hot winner as an index for the pointer update
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  assign w_lfsr_nxt = {r_lfsr[DW-2:0], r_lfsr[TAP_HI] ^ r_lfsr[TAP_LO]};
  assign w_ptr_nxt  = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
  assign w_hs       = o_vld_arb & i_rdy_arb;
  assign w_req_ok   = |(i_req_arb & r_gnt);

  // State register
  always_ff @(posedge i_clk_arb) begin
    if (i_rst_arb) r_state <= ST_ARB;
    else           r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_seed_cap  = 1'b0;
    w_seed_load = 1'b0;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_end       = 1'b0;
    o_vld_arb   = 1'b0;
    o_busy_arb  = 1'b1;
    case (r_state)
      ST_ARB: begin
        o_busy_arb = 1'b0;
        if (i_seed_vld_arb) begin
          w_seed_cap  = 1'b1;
          w_state_nxt = ST_SEED;
        end else if (|i_req_arb) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_SEED: begin
        w_seed_load = 1'b1;
        w_state_nxt = ST_ARB;
      end
      ST_BURST: begin
        o_vld_arb = 1'b1;
        w_adv     = i_rdy_arb;
        // Last word accepted, or the owner withdrew its request
        if ((i_rdy_arb && r_cnt == '0) || !w_req_ok) begin
          w_end       = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // LFSR, seed capture, burst counter, grant and pointer
  always_ff @(posedge i_clk_arb) begin
    if (i_rst_arb) begin
      r_lfsr <= c_SEED_RST;
      r_seed <= '0;
      r_ptr  <= '0;
      r_win  <= '0;
      r_cnt  <= '0;
      r_gnt  <= '0;
    end else begin
      if (w_seed_cap) r_seed <= i_seed_arb;
      if (w_seed_load) r_lfsr <= (r_seed == '0) ? DW'(1) : r_seed;
      else if (w_adv)  r_lfsr <= w_lfsr_nxt;
      if (w_start) begin
        r_gnt <= w_pick;
        r_win <= w_pick_idx;
        r_cnt <= c_CNT_LD;
      end else if (w_end) begin
        r_gnt <= '0;
        r_ptr <= w_ptr_nxt;
      end else if (w_adv && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_gnt_arb = r_gnt;
  assign o_rnd_arb = r_lfsr;

endmodule : lfsr_arb
`default_nettype wire

// File: tb/tb_lfsr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_arb
//  Purpose  : Self-checking bench for lfsr_arb with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_arb;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int BL = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic          seed_vld;
  logic [DW-1:0] seed;
  logic          rdy;
  logic [N-1:0]  gnt;
  logic          vld;
  logic [DW-1:0] rnd;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 seed load pending, 2 delivering a burst
  int m_ph   = 0;
  int m_lfsr = 1;
  int m_ptr  = 0;
  int m_win  = 0;
  int m_left = 0;
  int m_seed = 0;

  lfsr_arb #(
    .N_REQ     (N),
    .DW        (DW),
    .BURST_LEN (BL),
    .SEED_DEF  (1)
  ) dut (
    .i_clk_arb      (clk),
    .i_rst_arb      (rst),
    .i_req_arb      (req),
    .i_seed_vld_arb (seed_vld),
    .i_seed_arb     (seed),
    .i_rdy_arb      (rdy),
    .o_gnt_arb      (gnt),
    .o_vld_arb      (vld),
    .o_rnd_arb      (rnd),
    .o_busy_arb     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lfsr_step(input int v);
    return ((v << 1) | (((v >> 4) ^ (v >> 1)) & 1)) & ((1 << DW) - 1);
  endfunction

  function automatic int rr_winner(input int r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic sv,
                     input logic [DW-1:0] sd, input logic y);
    rst = r; req = q; seed_vld = sv; seed = sd; rdy = y;
    if (r) begin
      m_ph = 0; m_lfsr = 1; m_ptr = 0; m_left = 0;
    end else begin
      case (m_ph)
        0: if (sv) begin
             m_seed = int'(sd); m_ph = 1;
           end else if (q != '0) begin
             m_win = rr_winner(int'(q), m_ptr); m_left = BL; m_ph = 2;
           end
        1: begin
             m_lfsr = (m_seed == 0) ? 1 : m_seed; m_ph = 0;
           end
        default: begin
          if (y) begin
            m_lfsr = lfsr_step(m_lfsr); m_left--;
          end
          if (m_left == 0 || !q[m_win]) begin
            m_ph = 0; m_ptr = (m_win + 1) % N;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("gnt",  32'(gnt),  (m_ph == 2) ? 32'(1 << m_win) : 32'h0);
    chk("vld",  32'(vld),  32'(m_ph == 2));
    chk("rnd",  32'(rnd),  32'(m_lfsr));
    chk("busy", 32'(busy), 32'(m_ph != 0));
  endtask

  int held;
  int s0;

  initial begin
    rst = 1'b1; req = '0; seed_vld = 1'b0; seed = '0; rdy = 1'b0;

    // Reset state
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    chk("rst_rnd", 32'(rnd), 32'h01);
    chk("rst_gnt", 32'(gnt), 32'h0);

    // Single requester, always ready: 01 02 05 0A then back to idle
    cyc(0, 4'b0001, 0, 0, 1); chk("b1_w0", 32'(rnd), 32'h01); chk("b1_gnt", 32'(gnt), 32'h1);
    cyc(0, 4'b0001, 0, 0, 1); chk("b1_w1", 32'(rnd), 32'h02);
    cyc(0, 4'b0001, 0, 0, 1); chk("b1_w2", 32'(rnd), 32'h05);
    cyc(0, 4'b0001, 0, 0, 1); chk("b1_w3", 32'(rnd), 32'h0A);
    cyc(0, 4'b0000, 0, 0, 1); chk("b1_end_vld", 32'(vld), 32'h0);
    cyc(0, 4'b0000, 0, 0, 1);

    // All requesting: rotation 0001 0010 0100 1000 0001 with 4 words each
    cyc(1, 4'b0000, 0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      cyc(0, 4'b1111, 0, 0, 1);
      chk("rr_gnt", 32'(gnt), 32'(1 << (b % 4)));
      for (int w = 0; w < 3; w++) cyc(0, 4'b1111, 0, 0, 1);
      cyc(0, 4'b1111, 0, 0, 1);
      chk("rr_gap", 32'(vld), 32'h0);
    end
    cyc(0, 4'b0000, 0, 0, 1);

    // Seed load: zero becomes 01, 0A starts the next burst at 0A, 15
    cyc(0, 4'b0000, 1, 6'h00, 0); chk("seed_busy", 32'(busy), 32'h1);
    cyc(0, 4'b0000, 0, 0, 0);     chk("seed0", 32'(rnd), 32'h01);
    cyc(0, 4'b0000, 1, 6'h0A, 0);
    cyc(0, 4'b0000, 0, 0, 0);     chk("seedA", 32'(rnd), 32'h0A);
    cyc(0, 4'b0001, 0, 0, 1);     chk("seedA_w0", 32'(rnd), 32'h0A);
    cyc(0, 4'b0001, 1, 6'h33, 1); chk("seedA_w1", 32'(rnd), 32'h15);
    cyc(0, 4'b0001, 0, 0, 1);
    cyc(0, 4'b0001, 0, 0, 1);
    cyc(0, 4'b0000, 0, 0, 1);     chk("seed_ign", 32'(busy), 32'h0);

    // Stall for three cycles mid-burst
    cyc(0, 4'b0010, 0, 0, 1);
    cyc(0, 4'b0010, 0, 0, 1);
    held = m_lfsr;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 4'b0010, 0, 0, 0);
      chk("stall_rnd", 32'(rnd), 32'(held));
      chk("stall_gnt", 32'(gnt), 32'h2);
    end
    for (int k = 0; k < 3; k++) cyc(0, 4'b0010, 0, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0);

    // Owner drops after two handshakes: abort, LFSR two steps on, next owner
    s0 = m_lfsr;
    cyc(0, 4'b0100, 0, 0, 1);
    cyc(0, 4'b0100, 0, 0, 1);
    cyc(0, 4'b0100, 0, 0, 1);
    cyc(0, 4'b1000, 0, 0, 0);
    chk("abort_vld", 32'(vld), 32'h0);
    chk("abort_rnd", 32'(rnd), 32'(lfsr_step(lfsr_step(s0))));
    cyc(0, 4'b1000, 0, 0, 1);
    chk("abort_next", 32'(gnt), 32'h8);
    for (int k = 0; k < 4; k++) cyc(0, 4'b0000, 0, 0, 1);

    // Reset on the third burst word
    cyc(0, 4'b0010, 0, 0, 1);
    cyc(0, 4'b0010, 0, 0, 1);
    cyc(0, 4'b0010, 0, 0, 1);
    cyc(1, 4'b0010, 0, 0, 1);
    chk("mid_rst_vld", 32'(vld), 32'h0);
    chk("mid_rst_rnd", 32'(rnd), 32'h01);
    cyc(0, 4'b1111, 0, 0, 1);
    chk("mid_rst_ptr", 32'(gnt), 32'h1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(63) == 0),
          N'($urandom_range(15)),
          ($urandom_range(7) == 0),
          DW'($urandom),
          ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lfsr_arb
`default_nettype wire

// File: doc/lfsr_arb.md
LFSR_ARB -- requirements
Module: lfsr_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DW, default 6: random word width, 6..16.
REQ-003 Parameter BURST_LEN, default 4: words delivered per grant, 1..16.
REQ-004 Parameter SEED_DEF, default 1: LFSR value after reset.
REQ-005 i_clk_arb  in  1  single clock; every flop is updated on its rising edge.
REQ-006 i_rst_arb  in  1  synchronous, active-high reset.
REQ-007 i_req_arb  in  N_REQ  per-requester request level.
REQ-008 i_seed_vld_arb  in  1  seed load request.
REQ-009 i_seed_arb  in  DW  seed value.
REQ-010 i_rdy_arb  in  1  granted consumer accepts the word.
REQ-011 o_gnt_arb  out  N_REQ  one-hot grant; all zero when idle.
REQ-012 o_vld_arb  out  1  o_rnd_arb is valid.
REQ-013 o_rnd_arb  out  DW  current LFSR word.
REQ-014 o_busy_arb  out  1  high in any state other than ARB.

Function
REQ-015 The LFSR SHALL be internal: next = {lfsr[DW-2:0], lfsr[4]^lfsr[1]}.
REQ-016 The FSM SHALL have three states: ARB, SEED and BURST.
REQ-017 In ARB, i_seed_vld_arb=1 SHALL take priority over requests, capture i_seed_arb and go to SEED.
REQ-018 SEED SHALL last exactly one cycle, write the LFSR with the captured seed (a zero seed is replaced by 1), then return to ARB.
REQ-019 In ARB with no seed request and any i_req_arb bit set, the block SHALL grant the round-robin winner and load the burst counter with BURST_LEN-1.
  - Search for the winner starts at the pointer.
  - The FSM then goes to BURST.
REQ-020 The round-robin pointer SHALL reset to 0 and, on leaving BURST, become (winner+1) mod N_REQ.
REQ-021 In BURST, o_vld_arb=1, o_gnt_arb=winner and o_rnd_arb=LFSR SHALL hold; the grant is registered and stable for the whole burst.
REQ-022 A handshake is o_vld_arb & i_rdy_arb.
  - Only a handshake SHALL advance the LFSR and decrement the counter.
  - The sequence never skips a word.
REQ-023 A handshake with counter=0 SHALL return the FSM to ARB next cycle, with o_vld_arb=0 and o_gnt_arb=0.
REQ-024 If the granted i_req_arb bit is 0 in a BURST cycle without a handshake, the burst SHALL abort to ARB with the pointer updated.
REQ-025 If the granted request drops in the same cycle as a handshake, the handshake SHALL count and the burst SHALL then abort.
REQ-026 i_seed_vld_arb during SEED or BURST SHALL be ignored and not queued.
REQ-027 Latency from request sampled in ARB to first o_vld_arb SHALL be 1 cycle; at most one ARB cycle separates consecutive bursts.
REQ-028 o_rnd_arb SHALL show the LFSR in every state, including outside BURST.

Reset
REQ-029 Reset SHALL put the FSM in ARB, the LFSR at SEED_DEF (1 if SEED_DEF is 0), the pointer at 0 and the counter at 0.
REQ-030 Reset SHALL drive o_gnt_arb=0, o_vld_arb=0, o_busy_arb=0 and o_rnd_arb=SEED_DEF.
REQ-031 Reset asserted mid-burst or in SEED SHALL discard the transfer and any captured seed in the same edge.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the tap indices (4, 1); DW < 6 is a static error.
REQ-033 One sub-module, rr_pick, SHALL hold the combinational round-robin winner select (req vector and pointer in, one-hot out).

Verification
REQ-034 Reset, then req=0001 with rdy=1 held SHALL give gnt=0001 and o_rnd 01, 02, 05, 0A on consecutive cycles, then ARB.
REQ-035 req=1111 with rdy=1 held SHALL give grants in the order 0001, 0010, 0100, 1000, 0001, each lasting 4 words.
REQ-036 Seed 6'h00 in ARB SHALL load 01; seed 6'h0A SHALL give a next burst starting 0A, 15.
REQ-037 rdy=0 for 3 cycles mid-burst SHALL hold o_rnd and the grant stable, with no LFSR advance.
REQ-038 The granted req dropping after 2 handshakes SHALL abort, leave the LFSR two steps advanced, and grant the next requester.
REQ-039 Reset during the third burst word SHALL give o_vld=0, o_rnd=01 and ptr=0 on the next cycle.
